// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default frame geometry and
// the mid-bit tick index used by the transmitter, receiver and baud generator.
package uart_pkg;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Tick index that lands in the middle of a bit cell.
    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte stream: one-entry valid/ready holding register plus
// busy and error strobes. The receiver is master, the consumer is slave.
interface uart_rx_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_busy;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        output rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_busy, rx_frame_err, rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset
// to RESET_VAL so the output never shows a spurious edge after reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the synchronized line on the shared baud
// tick, samples each bit at mid-cell and hands bytes to a valid/ready register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick,
    input  logic      rx_line,
    uart_rx_if.master rx_bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_tick(OVERSAMPLE));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_ok, stop_bad;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, busy_q, ferr_q, ovr_q;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_line),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            S_IDLE: if (tick && !rx_s) begin
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: if (tick) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_MID) begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: if (tick) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) state_d = S_STOP;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_STOP: if (tick) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    stop_ok  = rx_s;
                    stop_bad = !rx_s;
                    state_d  = rx_s ? S_IDLE : S_WAIT_IDLE;
                end
            end
            // A held-low line (break) must go high once before a new start is armed.
            S_WAIT_IDLE: if (tick && rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            ferr_q <= stop_bad;
            ovr_q  <= 1'b0;
            if (stop_ok) begin
                // A consume on the delivery clock frees the slot for the new byte.
                if (!valid_q || rx_bus.rx_ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data      = data_q;
    assign rx_bus.rx_valid     = valid_q;
    assign rx_bus.rx_busy      = busy_q;
    assign rx_bus.rx_frame_err = ferr_q;
    assign rx_bus.rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial driver plus a
// frame-level model of what each frame must produce on the byte interface.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int OS8      = 8;
    localparam int DB       = 8;
    localparam int TICK_DIV = 4;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic tick     = 1'b0;
    logic rx_line  = 1'b1;
    logic rx_line8 = 1'b1;

    uart_rx_if #(.DATA_BITS(DB)) bus ();
    uart_rx_if #(.DATA_BITS(DB)) bus8 ();

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .rx_line (rx_line),
        .rx_bus  (bus)
    );

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .rx_line (rx_line8),
        .rx_bus  (bus8)
    );

    always #5 clk = ~clk;

    int div = 0;
    always @(negedge clk) begin
        tick = (div == TICK_DIV - 1);
        div  = (div == TICK_DIV - 1) ? 0 : div + 1;
    end

    // Monitor: samples 1 ns before each rising edge.
    int   tick_count = 0;
    int   ferr_cnt = 0, ovr_cnt = 0, bad8_cnt = 0;
    int   valid_rise_cnt = 0, busy_rise_cnt = 0;
    int   valid_rise_tick = 0, busy_fall_tick = 0;
    logic valid_d = 1'b0, busy_d = 1'b0;
    logic [7:0] got_q[$];

    always begin
        @(negedge clk);
        #4;
        if (tick) tick_count++;
        if (rst_n) begin
            if (bus.rx_frame_err) ferr_cnt++;
            if (bus.rx_overrun)   ovr_cnt++;
            if (bus8.rx_frame_err || bus8.rx_overrun) bad8_cnt++;
            if (bus.rx_valid && !valid_d) begin
                valid_rise_cnt++;
                valid_rise_tick = tick_count;
            end
            if (bus.rx_busy && !busy_d) busy_rise_cnt++;
            if (!bus.rx_busy && busy_d) busy_fall_tick = tick_count;
            if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
        end
        valid_d = bus.rx_valid;
        busy_d  = bus.rx_busy;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns on the falling edge right after the n-th further tick.
    task automatic wait_ticks(input int n);
        int target;
        target = tick_count + n;
        while (tick_count < target) @(negedge clk);
    endtask

    task automatic drive(input bit use8, input logic v);
        if (use8) rx_line8 = v;
        else      rx_line  = v;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int os,
                              input bit use8, input int low_tail);
        drive(use8, 1'b0);
        wait_ticks(os);
        for (int i = 0; i < DB; i++) begin
            drive(use8, b[i]);
            wait_ticks(os);
        end
        drive(use8, stop);
        wait_ticks(os * (1 + low_tail));
        drive(use8, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, f0, o0, v0, b0, exp_ferr;
        logic [7:0] b;
        logic       stop;
        logic [7:0] exp_q[$];
        logic [7:0] lb[3];

        bus.rx_ready  = 1'b1;
        bus8.rx_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_data",  32'(bus.rx_data),      32'h0);
        check("rst_valid", 32'(bus.rx_valid),     32'h0);
        check("rst_busy",  32'(bus.rx_busy),      32'h0);
        check("rst_ferr",  32'(bus.rx_frame_err), 32'h0);
        check("rst_ovr",   32'(bus.rx_overrun),   32'h0);
        wait_ticks(3);
        rst_n = 1'b1;
        wait_ticks(4);

        // Loopback-style stream with ready held high
        lb[0] = 8'hA5; lb[1] = 8'h00; lb[2] = 8'hFF;
        got_q.delete();
        f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_rise_cnt;
        st = tick_count;
        send_frame(lb[0], 1'b1, OS, 1'b0, 0);
        check("lb_latency", 32'(valid_rise_tick - st), 32'(1 + OS / 2 + DB * OS + OS));
        wait_ticks($urandom_range(0, OS));
        send_frame(lb[1], 1'b1, OS, 1'b0, 0);
        send_frame(lb[2], 1'b1, OS, 1'b0, 0);
        wait_ticks(OS);
        check("lb_count",  32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("lb_byte", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(lb[i]));
        check("lb_vrises", 32'(valid_rise_cnt - v0), 32'd3);
        check("lb_ferr",   32'(ferr_cnt - f0), 32'd0);
        check("lb_ovr",    32'(ovr_cnt - o0),  32'd0);

        // Glitch shorter than half a bit
        f0 = ferr_cnt; v0 = valid_rise_cnt; b0 = busy_rise_cnt;
        st = tick_count;
        rx_line = 1'b0;
        wait_ticks(4);
        rx_line = 1'b1;
        wait_ticks(2 * OS);
        check("gl_busy_rise", 32'(busy_rise_cnt - b0), 32'd1);
        check("gl_busy_end",  32'(busy_fall_tick - st), 32'(1 + OS / 2));
        check("gl_busy",      32'(bus.rx_busy), 32'h0);
        check("gl_valid",     32'(valid_rise_cnt - v0), 32'd0);
        check("gl_ferr",      32'(ferr_cnt - f0), 32'd0);

        // Framing error followed by a break, then a clean frame
        got_q.delete();
        f0 = ferr_cnt; v0 = valid_rise_cnt;
        send_frame(8'h3C, 1'b0, OS, 1'b0, 3);
        check("fe_busy_held", 32'(bus.rx_busy), 32'h1);
        wait_ticks(2);
        check("fe_busy_end",  32'(bus.rx_busy), 32'h0);
        check("fe_pulses",    32'(ferr_cnt - f0), 32'd1);
        check("fe_valid",     32'(valid_rise_cnt - v0), 32'd0);
        send_frame(8'h55, 1'b1, OS, 1'b0, 0);
        wait_ticks(OS);
        check("fe_next", (got_q.size() == 1) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'h55);

        // Overrun with the consumer stalled
        bus.rx_ready = 1'b0;
        got_q.delete();
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, OS, 1'b0, 0);
        wait_ticks(2);
        send_frame(8'h22, 1'b1, OS, 1'b0, 0);
        wait_ticks(OS);
        check("ov_data",   32'(bus.rx_data),  32'h11);
        check("ov_valid",  32'(bus.rx_valid), 32'h1);
        check("ov_pulses", 32'(ovr_cnt - o0), 32'd1);

        // Consume on exactly the delivery clock of the next byte
        o0 = ovr_cnt;
        st = tick_count;
        fork
            send_frame(8'h22, 1'b1, OS, 1'b0, 0);
            begin
                wait_ticks(1 + OS / 2 + DB * OS + OS - 1);
                repeat (TICK_DIV - 1) @(negedge clk);
                bus.rx_ready = 1'b1;
                @(negedge clk);
                bus.rx_ready = 1'b0;
            end
        join
        wait_ticks(OS);
        check("sim_data",     32'(bus.rx_data),  32'h22);
        check("sim_valid",    32'(bus.rx_valid), 32'h1);
        check("sim_ovr",      32'(ovr_cnt - o0), 32'd0);
        check("sim_consumed", (got_q.size() == 1) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'h11);

        // Asynchronous reset in the middle of data bit 4 of 0x96
        b = 8'h96;
        rx_line = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            rx_line = b[i];
            wait_ticks(OS);
        end
        rx_line = b[4];
        wait_ticks(OS / 2);
        check("mr_busy_before", 32'(bus.rx_busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_data",  32'(bus.rx_data),      32'h0);
        check("mr_valid", 32'(bus.rx_valid),     32'h0);
        check("mr_busy",  32'(bus.rx_busy),      32'h0);
        check("mr_ferr",  32'(bus.rx_frame_err), 32'h0);
        check("mr_ovr",   32'(bus.rx_overrun),   32'h0);
        rx_line = 1'b1;
        wait_ticks(4);
        rst_n = 1'b1;
        b0 = busy_rise_cnt; v0 = valid_rise_cnt;
        wait_ticks(2 * OS);
        check("mr_no_start", 32'(busy_rise_cnt - b0), 32'd0);
        check("mr_no_valid", 32'(valid_rise_cnt - v0), 32'd0);
        bus.rx_ready = 1'b1;
        got_q.delete();
        send_frame(8'h69, 1'b1, OS, 1'b0, 0);
        wait_ticks(OS);
        check("mr_next", (got_q.size() == 1) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'h69);

        // Randomized frames against the frame-level model
        got_q.delete();
        exp_q.delete();
        exp_ferr = 0;
        f0 = ferr_cnt; o0 = ovr_cnt;
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            if (stop) exp_q.push_back(b);
            else      exp_ferr++;
            send_frame(b, stop, OS, 1'b0, stop ? 0 : $urandom_range(0, 2));
            wait_ticks(stop ? $urandom_range(0, OS) : $urandom_range(2, OS));
        end
        wait_ticks(2 * OS);
        check("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            check("rnd_byte", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        check("rnd_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
        check("rnd_ovr",  32'(ovr_cnt - o0),  32'd0);

        // Receiver built for 8x oversampling
        b = 8'($urandom);
        send_frame(8'hC3, 1'b1, OS8, 1'b1, 0);
        wait_ticks(OS8);
        check("os8_valid", 32'(bus8.rx_valid), 32'h1);
        check("os8_data",  32'(bus8.rx_data),  32'hC3);
        bus8.rx_ready = 1'b1;
        @(negedge clk);
        bus8.rx_ready = 1'b0;
        send_frame(b, 1'b1, OS8, 1'b1, 0);
        wait_ticks(OS8);
        check("os8_rand",  32'(bus8.rx_data),  32'(b));
        check("os8_err",   32'(bad8_cnt),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver (8N1). It is the downstream partner of uart_tx and consumes its serial line, either in loopback or from an external pin. It uses the shared 16x baud tick to oversample the line, validates the start bit at mid-bit, samples data LSB-first at mid-bit, and checks the stop bit. Each received byte is presented on a one-entry valid/ready holding register, with framing-error and overrun reporting.

Parameters:
DATA_BITS, 8, data bits per frame.
OVERSAMPLE, 16, ticks per bit. Must be even and >=4. Counter width is clog2(OVERSAMPLE).

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous, active-low reset
tick  input  1  one-clk pulse at OVERSAMPLE x baud (shared baud generator)
rx_line  input  1  serial input, idle high, asynchronous to clk
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready at a clk edge
rx_data  output  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  output  1  holding register full
rx_busy  output  1  high from start detection until return to IDLE/WAIT_IDLE exit
rx_frame_err  output  1  one-clk pulse: stop bit sampled 0
rx_overrun  output  1  one-clk pulse: completed byte dropped because the holding register was full

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counters=0, shift_reg=0. Outputs: rx_data=0, rx_valid=0, rx_busy=0, rx_frame_err=0, rx_overrun=0. Both synchronizer flops reset to 1 so no false start is seen. Reset mid-frame abandons the frame with no error pulse.
- rx_line passes through a 2-FF synchronizer. All decisions use the synchronized value rx_s, so line-to-decision latency is 2 clk.
- Counters advance only on clk edges where tick=1. Between ticks, state and counters hold.
- Ticks are counted with a counter `cnt`. MID = OVERSAMPLE/2-1 (7 by default).
- IDLE: rx_busy=0. On tick with rx_s=0: cnt<=0, go to START, rx_busy<=1.
- START: on each tick, cnt++. When cnt==MID:
  - if rx_s=0: cnt<=0, bit_idx<=0, go to DATA.
  - else (glitch): go to IDLE, rx_busy<=0, no error pulse.
- DATA: on each tick, cnt++. When cnt==OVERSAMPLE-1:
  - sample: shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]} (LSB first); cnt<=0.
  - after bit DATA_BITS-1 is sampled, go to STOP; otherwise bit_idx++.
- STOP: on each tick, cnt++. When cnt==OVERSAMPLE-1 (mid stop bit):
  - rx_s=1: deliver shift_reg (see handshake), go to IDLE, rx_busy<=0.
  - rx_s=0: rx_frame_err pulses 1 clk, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: rx_busy=1. On tick with rx_s=1, go to IDLE (rx_busy<=0). This prevents a break condition from retriggering continuously.
- Handshake and delivery, evaluated on the delivery clk:
  - rx_valid=0: rx_data<=shift_reg, rx_valid<=1 (registered; visible the clk after the stop-bit sample).
  - rx_valid=1 && rx_ready=1 on the same clk: old byte is consumed, new byte is loaded, rx_valid stays 1, no overrun.
  - rx_valid=1 && rx_ready=0: new byte dropped, rx_data unchanged, rx_overrun pulses 1 clk.
- Outside delivery, rx_valid && rx_ready clears rx_valid on the next edge. rx_data retains its last value.
- Back-to-back frames: exit at mid stop bit leaves half a bit of margin for the next start edge.
- Illegal state encodings go to IDLE.

Decomposition:
- Package uart_pkg holds:
  - state localparams: S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE (3-bit).
  - default OVERSAMPLE=16 and DATA_BITS=8.
  - MID derivation, shared with uart_tx and the baud generator.
- One sub-module, uart_sync2: 2-FF synchronizer with RESET_VAL parameter (here 1). It is reusable for other async inputs.

Test Plan:
- Loopback with uart_tx and the shared tick: send 0xA5, then 0x00, then 0xFF with rx_ready=1 -> rx_data=0xA5, 0x00, 0xFF in order. Each rx_valid asserts once, ~9.5 bit-times after the start edge. No err/overrun.
- Glitch: drive rx_line low for 4 ticks, then high -> state returns to IDLE after tick MID. rx_busy pulse ends, rx_valid stays 0, no err.
- Framing: frame 0x3C with stop bit forced 0, then line held low 3 bit-times, then high -> one rx_frame_err pulse, rx_valid=0. rx_busy stays 1 until the first tick with rx_s=1. A following 0x55 is received correctly.
- Overrun/simultaneous: send 0x11 and 0x22 with rx_ready=0 -> rx_data=0x11, one rx_overrun pulse at the 0x22 stop sample. Repeat with rx_ready=1 exactly on the delivery clk -> rx_data=0x22, rx_valid stays 1, no overrun.
- Reset mid-frame: assert rx_n low during data bit 4 of 0x96 -> all outputs 0 immediately (async). After release with the line idle high, no spurious start. A next frame 0x69 is received correctly.
- OVERSAMPLE=8 build: loopback 0xC3 with a matching tx -> received 0xC3.
